vend_sequencer: RTL and testbench
=================================

# vend_sequencer

Dispense controller for the vending-machine datapath. Accumulates inserted credit and latches selection-button presses, then arbitrates among pending selections. For each winner it drives exactly one dispenser output for a fixed pulse width, followed by a mandatory gap. It sits between the selection switches/coin acceptor and the dispenser outputs, and exports credit and busy status for the 7-segment display driver.

## Interface
- NUM_SLOTS, 6, number of selection inputs and dispenser outputs (2..8)
- PRICE, 8'd50, credit charged per vend
- DISPENSE_CYCLES, 125000000, cycles a dispenser output is held high (≥1)
- GAP_CYCLES, 25000000, cycles with all outputs low after each vend (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Selection  in  NUM_SLOTS  level selection buttons, one per slot, synchronous to clk
- coin_valid  in  1  one-cycle pulse, coin accepted
- coin_value  in  8  coin value, sampled when coin_valid=1
- Despensing  out  NUM_SLOTS  one-hot (or zero) dispenser drive
- grant_idx  out  3  slot being served; holds last served value otherwise
- busy  out  1  high in DISPENSE and GAP
- done  out  1  one-cycle pulse on the first GAP cycle
- credit  out  8  current credit, unsigned

## Operation
- Edge detect: sel_q <= Selection each cycle. A rising edge on bit i sets pending[i].
- Credit: on coin_valid, credit <= min(credit + coin_value, 255). The add saturates before any vend deduction in the same cycle.
- FSM states are IDLE, DISPENSE and GAP.
- IDLE: if (pending & eligible) != 0 and registered credit ≥ PRICE, then:
  - select a winner
  - clear pending[winner]
  - load grant_idx
  - credit <= sat(credit + coin) − PRICE
  - go to DISPENSE
  - Otherwise stay in IDLE.
- DISPENSE: Despensing[grant_idx]=1 for exactly DISPENSE_CYCLES cycles, then go to GAP.
- GAP: all outputs low for exactly GAP_CYCLES cycles, done=1 on the first GAP cycle, then go to IDLE.
- Phase length uses a single down-counter of width $clog2(max(DISPENSE_CYCLES, GAP_CYCLES)+1).
- Arbitration with round-robin: search starts at last_grant+1 and wraps at NUM_SLOTS−1 → 0. last_grant resets to NUM_SLOTS−1, so slot 0 has first priority after reset.
- Simultaneous set and clear of pending[i] in one cycle: set wins, so the new press is queued again.
- A press on a slot while that slot is being served is queued and served on a later vend.
- With insufficient credit, pending requests are retained indefinitely. Coins keep accumulating in every state.
- Reset, including mid-dispense, takes effect on the next clk edge:
  - state=IDLE
  - Despensing=0, busy=0, done=0, credit=0, grant_idx=0, pending=0
  - counter=0
  - sel_q <= Selection, so buttons held through reset do not register as presses

## Timing
- Press sampled at edge N → pending at N+1 → Despensing high from N+2 when credit suffices and the FSM is IDLE. Minimum latency is 2 cycles.
- Vend period is DISPENSE_CYCLES + GAP_CYCLES + 1 cycles. The +1 is the IDLE decision cycle.
- done asserts at cycle N+2+DISPENSE_CYCLES, one cycle wide.
- Every output is registered. Despensing never has more than one bit set, and never goes high in GAP.

## Configuration
- VEND_ROUND_ROBIN_EN defined: round-robin arbitration as described above.
- VEND_ROUND_ROBIN_EN undefined: fixed priority, lowest pending index wins. last_grant is not implemented.
- All other behaviour is identical in both builds.

## Structure
- Package vend_pkg holds:
  - state enum (IDLE, DISPENSE, GAP)
  - CREDIT_W=8
  - CREDIT_MAX=255
  - the saturating-add function
- Sub-module vend_rr_arbiter takes pending and last_grant and produces a one-hot grant plus index.
  - It is combinational.
  - Its fixed-priority mode is selected by VEND_ROUND_ROBIN_EN.

## Test plan
Bench parameters: PRICE=50, DISPENSE_CYCLES=4, GAP_CYCLES=2.
- Two coins of 25, then press slot 2 → Despensing=6'b000100 for 4 cycles, done 1 cycle, credit=0, busy low after 2 GAP cycles.
- Credit 100; press slots 1, 3 and 4 in the same cycle → serves 1, 3 with round-robin; with the macro undefined, same order 1, 3 (fixed priority). Slot 4 stays pending, credit=0.
- Round-robin fairness:
  - Credit 200; slot 0 served, then press slots 0 and 5 together → 5 served before 0.
  - With the macro undefined → 0 served before 5.
- Credit 250, then a coin of 25 → credit=255 (saturated). A vend in the same cycle as a coin of 10 → 205.
- Reset asserted on DISPENSE cycle 2 while Selection[1] is held → next cycle Despensing=0, credit=0. After reset releases, there is no vend until slot 1 is released and pressed again.
- Press slot 3 with credit 40 → no vend. Add 10 → vend starts 1 cycle after credit reaches 50.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending dispense controller.
// Build option: VEND_ROUND_ROBIN_EN selects round-robin arbitration.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        GAP      = 2'd2
    } state_t;

    localparam int CREDIT_W = 8;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 8'd255;

    // Credit add that clamps at CREDIT_MAX instead of wrapping.
    function automatic logic [CREDIT_W-1:0] sat_add(
        input logic [CREDIT_W-1:0] a,
        input logic [CREDIT_W-1:0] b
    );
        logic [CREDIT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CREDIT_W] ? CREDIT_MAX : sum[CREDIT_W-1:0];
    endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational arbiter picking one pending slot per vend.
// VEND_ROUND_ROBIN_EN: round-robin after last_grant, else lowest index.
module vend_rr_arbiter
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS = 6
) (
    input  logic [NUM_SLOTS-1:0] pending,
`ifdef VEND_ROUND_ROBIN_EN
    input  logic [2:0]           last_grant,
`endif
    output logic [NUM_SLOTS-1:0] grant,
    output logic [2:0]           idx,
    output logic                 found
);

`ifdef VEND_ROUND_ROBIN_EN
    int cand;

    // Scan from the slot after the previous winner, wrapping to 0.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            cand = (int'(last_grant) + k) % NUM_SLOTS;
            if (!found && pending[cand]) begin
                found       = 1'b1;
                idx         = 3'(cand);
                grant[cand] = 1'b1;
            end
        end
    end
`else
    // Lowest pending index always wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && pending[i]) begin
                found    = 1'b1;
                idx      = 3'(i);
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/vend_sequencer.sv
// Dispense controller: credit, press latching, arbitration, pulse/gap.
// Build option: VEND_ROUND_ROBIN_EN enables round-robin slot arbitration.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int             NUM_SLOTS       = 6,
    parameter logic [7:0]     PRICE           = 8'd50,
    parameter int             DISPENSE_CYCLES = 125000000,
    parameter int             GAP_CYCLES      = 25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SLOTS-1:0] Selection,
    input  logic                 coin_valid,
    input  logic [7:0]           coin_value,
    output logic [NUM_SLOTS-1:0] Despensing,
    output logic [2:0]           grant_idx,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           credit
);

    localparam int MAX_CYCLES =
        (DISPENSE_CYCLES > GAP_CYCLES) ? DISPENSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [NUM_SLOTS-1:0] sel_q;
    logic [NUM_SLOTS-1:0] pending;
    logic [NUM_SLOTS-1:0] rise;
    logic [NUM_SLOTS-1:0] win_grant;
    logic [2:0]           win_idx;
    logic                 win_found;
    logic [7:0]           credit_in;
    logic                 vend;
`ifdef VEND_ROUND_ROBIN_EN
    logic [2:0]           last_grant;
`endif

    assign rise      = Selection & ~sel_q;
    assign credit_in = sat_add(credit, coin_valid ? coin_value : 8'd0);
    assign vend      = (state == IDLE) && win_found && (credit >= PRICE);

    vend_rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_arb (
        .pending    (pending),
`ifdef VEND_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant      (win_grant),
        .idx        (win_idx),
        .found      (win_found)
    );

    // Press latching, credit and the IDLE/DISPENSE/GAP sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            sel_q      <= Selection;
            pending    <= '0;
            credit     <= '0;
            Despensing <= '0;
            grant_idx  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef VEND_ROUND_ROBIN_EN
            last_grant <= 3'(NUM_SLOTS - 1);
`endif
        end else begin
            sel_q   <= Selection;
            done    <= 1'b0;
            credit  <= credit_in;
            pending <= pending | rise;
            unique case (state)
                IDLE: begin
                    if (vend) begin
                        // A fresh press on the winner re-queues it.
                        pending    <= (pending & ~win_grant) | rise;
                        credit     <= credit_in - PRICE;
                        grant_idx  <= win_idx;
                        Despensing <= win_grant;
                        busy       <= 1'b1;
                        count      <= DISP_LOAD;
                        state      <= DISPENSE;
`ifdef VEND_ROUND_ROBIN_EN
                        last_grant <= win_idx;
`endif
                    end
                end
                DISPENSE: begin
                    if (count == '0) begin
                        Despensing <= '0;
                        done       <= 1'b1;
                        count      <= GAP_LOAD;
                        state      <= GAP;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer with a behavioural reference model.
// Honours VEND_ROUND_ROBIN_EN for the expected arbitration order.
module tb_vend_sequencer;

    localparam int NS = 6;
    localparam int DC = 4;
    localparam int GC = 2;
    localparam int PR = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] Selection = '0;
    logic          coin_valid = 1'b0;
    logic [7:0]    coin_value = '0;
    logic [NS-1:0] Despensing;
    logic [2:0]    grant_idx;
    logic          busy;
    logic          done;
    logic [7:0]    credit;

    always #5 clk = ~clk;

    vend_sequencer #(
        .NUM_SLOTS       (NS),
        .PRICE           (8'd50),
        .DISPENSE_CYCLES (DC),
        .GAP_CYCLES      (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Selection  (Selection),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .Despensing (Despensing),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .done       (done),
        .credit     (credit)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference model: credit as an integer, a set of waiting slots,
    // and a count of remaining busy cycles for the current vend.
    int      m_credit;
    bit      m_pend[NS];
    logic [NS-1:0] m_prev;
    int      m_last;
    int      m_left;
    int      m_cur;
    bit      m_done;
    int      exp_q[$];
    int      served[$];
    int      mc;
    int      mw;
    logic [NS-1:0] mr;

    function automatic int pick();
`ifdef VEND_ROUND_ROBIN_EN
        for (int k = 1; k <= NS; k++) begin
            if (m_pend[(m_last + k) % NS]) return (m_last + k) % NS;
        end
`else
        for (int i = 0; i < NS; i++) begin
            if (m_pend[i]) return i;
        end
`endif
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_credit = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_prev = Selection;
            m_last = NS - 1;
            m_left = 0;
            m_cur  = 0;
            m_done = 1'b0;
        end else begin
            mr = Selection & ~m_prev;
            m_prev = Selection;
            mc = m_credit + (coin_valid ? int'(coin_value) : 0);
            if (mc > 255) mc = 255;
            m_done = 1'b0;
            if (m_left == 0) begin
                mw = pick();
                if (mw >= 0 && m_credit >= PR) begin
                    m_pend[mw] = 1'b0;
                    mc = mc - PR;
                    exp_q.push_back(mw);
                    m_left = DC + GC;
                    m_cur  = mw;
                    m_last = mw;
                end
            end else begin
                m_left--;
                if (m_left == GC) m_done = 1'b1;
            end
            for (int i = 0; i < NS; i++) begin
                if (mr[i]) m_pend[i] = 1'b1;
            end
            m_credit = mc;
        end
    end

    // Monitor: per-cycle output check plus pop on each new dispense.
    bit            armed = 1'b0;
    logic [NS-1:0] prev_d = '0;
    logic [NS-1:0] exp_d;
    int            qw;

    initial forever begin
        @(negedge clk);
        if (armed) begin
            exp_d = (m_left > GC) ? NS'(1 << m_cur) : '0;
            chk("despensing", 32'(Despensing), 32'(exp_d));
            chk("credit", 32'(credit), 32'(m_credit));
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("grant_idx", 32'(grant_idx), 32'(m_cur));
            if (Despensing != '0 && prev_d == '0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_vend actual=%0d required=none",
                             grant_idx);
                end else begin
                    qw = exp_q.pop_front();
                    chk("vend_slot", 32'(grant_idx), 32'(qw));
                    served.push_back(int'(grant_idx));
                end
            end
        end
        prev_d = Despensing;
    end

    function automatic int sv(input int i);
        return (i < served.size()) ? served[i] : -1;
    endfunction

    task automatic cyc(input logic [NS-1:0] s, input bit cv,
                       input logic [7:0] v);
        @(negedge clk);
        #1;
        Selection  = s;
        coin_valid = cv;
        coin_value = v;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b0, 8'd0);
    endtask

    task automatic rst(input int n);
        cyc(Selection, 1'b0, 8'd0);
        reset = 1'b1;
        repeat (n) cyc(Selection, 1'b0, 8'd0);
        reset = 1'b0;
    endtask

    logic [NS-1:0] rs;
    int            rv;
    logic [7:0]    coins[6] = '{8'd5, 8'd10, 8'd25, 8'd50, 8'd100, 8'd200};

    initial begin
        repeat (3) cyc('0, 1'b0, 8'd0);
        reset = 1'b0;
        cyc('0, 1'b0, 8'd0);
        chk("rst_desp", 32'(Despensing), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_gidx", 32'(grant_idx), 0);
        armed = 1'b1;

        // Two 25 coins then slot 2.
        served.delete();
        cyc('0, 1'b1, 8'd25);
        cyc('0, 1'b1, 8'd25);
        cyc(6'b000100, 1'b0, 8'd0);
        idle(12);
        chk("t1_count", served.size(), 1);
        chk("t1_slot", sv(0), 2);
        chk("t1_credit", 32'(credit), 0);
        chk("t1_busy", 32'(busy), 0);

        // Three presses at once with credit for two.
        rst(2);
        served.delete();
        cyc('0, 1'b1, 8'd50);
        cyc('0, 1'b1, 8'd50);
        cyc(6'b011010, 1'b0, 8'd0);
        idle(20);
        chk("t2_count", served.size(), 2);
        chk("t2_first", sv(0), 1);
        chk("t2_second", sv(1), 3);
        chk("t2_credit", 32'(credit), 0);
        cyc('0, 1'b1, 8'd50);
        idle(10);
        chk("t2_retained", sv(2), 4);

        // Fairness: slot 0 served, then 0 and 5 together.
        rst(2);
        served.delete();
        cyc('0, 1'b1, 8'd100);
        cyc('0, 1'b1, 8'd100);
        cyc(6'b000001, 1'b0, 8'd0);
        idle(10);
        cyc(6'b100001, 1'b0, 8'd0);
        idle(20);
        chk("t3_first", sv(0), 0);
`ifdef VEND_ROUND_ROBIN_EN
        chk("t3_second", sv(1), 5);
        chk("t3_third", sv(2), 0);
`else
        chk("t3_second", sv(1), 0);
        chk("t3_third", sv(2), 5);
`endif
        chk("t3_credit", 32'(credit), 50);

        // Saturation and coin during the vend decision.
        rst(2);
        cyc('0, 1'b1, 8'd250);
        cyc('0, 1'b1, 8'd25);
        cyc('0, 1'b0, 8'd0);
        chk("t4_sat", 32'(credit), 255);
        cyc(6'b000010, 1'b0, 8'd0);
        cyc('0, 1'b1, 8'd10);
        cyc('0, 1'b0, 8'd0);
        chk("t4_vend_coin", 32'(credit), 205);
        idle(10);

        // Reset mid-dispense with slot 1 held.
        rst(2);
        served.delete();
        cyc('0, 1'b1, 8'd100);
        cyc(6'b000010, 1'b0, 8'd0);
        cyc(6'b000010, 1'b0, 8'd0);
        cyc(6'b000010, 1'b0, 8'd0);
        cyc(6'b000010, 1'b0, 8'd0);
        reset = 1'b1;
        cyc(6'b000010, 1'b0, 8'd0);
        reset = 1'b0;
        chk("t5_desp", 32'(Despensing), 0);
        chk("t5_credit", 32'(credit), 0);
        cyc(6'b000010, 1'b1, 8'd100);
        repeat (10) cyc(6'b000010, 1'b0, 8'd0);
        chk("t5_noreq", served.size(), 1);
        chk("t5_idle", 32'(busy), 0);
        cyc('0, 1'b0, 8'd0);
        cyc(6'b000010, 1'b0, 8'd0);
        idle(10);
        chk("t5_repress", sv(1), 1);

        // Credit reaches price after the press.
        rst(2);
        cyc('0, 1'b1, 8'd40);
        cyc(6'b001000, 1'b0, 8'd0);
        idle(6);
        chk("t6_wait_busy", 32'(busy), 0);
        chk("t6_wait_credit", 32'(credit), 40);
        cyc('0, 1'b1, 8'd10);
        cyc('0, 1'b0, 8'd0);
        cyc('0, 1'b0, 8'd0);
        chk("t6_start", 32'(Despensing), 32'(6'b001000));
        chk("t6_credit", 32'(credit), 0);
        idle(10);

        // Random traffic against the model.
        rst(2);
        rs = '0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0)
                rs = rs ^ NS'(1 << $urandom_range(0, NS - 1));
            rv = $urandom_range(0, 5);
            cyc(rs, ($urandom_range(0, 3) == 0), coins[rv]);
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
        idle(60);
        chk("drain_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
